// File: rtl/udiv_pkg.sv
// Shared types and constants for the iterative unsigned divider.
package udiv_pkg;

    localparam int UDIV_WIDTH = 32;
    localparam int CNT_W      = $clog2(UDIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Two's-complement negate when n is set, pass-through otherwise.
    function automatic logic [UDIV_WIDTH-1:0] neg_if(input logic [UDIV_WIDTH-1:0] v,
                                                     input logic n);
        return n ? (~v + UDIV_WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/add_32.sv
// 32-bit ripple-carry adder; also serves as the subtractor in the divider.
module add_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_31_o
);

    logic [32:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_31_o = c[32];

endmodule

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift {R,Q} left, trial-subtract divisor.
module div_step
    import udiv_pkg::*;
(
    input  logic [UDIV_WIDTH-1:0] r_i,
    input  logic                  q_msb_i,
    input  logic [UDIV_WIDTH-1:0] divisor_i,
    output logic [UDIV_WIDTH-1:0] r_o,
    output logic                  q_bit_o
);

    logic [UDIV_WIDTH-1:0] r_sh;
    logic [UDIV_WIDTH-1:0] diff;
    logic                  ext;
    logic                  cout;

    assign r_sh = {r_i[UDIV_WIDTH-2:0], q_msb_i};
    assign ext  = r_i[UDIV_WIDTH-1];

    add_32 u_sub (
        .a_i       (r_sh),
        .b_i       (~divisor_i),
        .cin_i     (1'b1),
        .sum_o     (diff),
        .cout_31_o (cout)
    );

    // The shifted-out bit is the 33rd bit of R; if set, T is non-negative regardless of cout.
    assign q_bit_o = cout | ext;
    assign r_o     = q_bit_o ? diff : r_sh;

endmodule

// File: rtl/udiv_32.sv
// Iterative 32-bit divider, one quotient bit per cycle (IDLE -> RUN x32 -> DONE).
// Optional signed mode enabled by defining DIV_SIGNED_EN (adds signed_op input).
module udiv_32
    import udiv_pkg::*;
#(
    parameter int WIDTH = UDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic [WIDTH-1:0] step_r, q_shift, a_mag, b_mag;
    logic             step_qbit, a_neg, b_neg, dvs_zero;

`ifdef DIV_SIGNED_EN
    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif

    assign a_mag    = neg_if(dividend, a_neg);
    assign b_mag    = neg_if(divisor, b_neg);
    assign dvs_zero = (divisor == '0);

    div_step u_step (
        .r_i       (r_q),
        .q_msb_i   (q_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .r_o       (step_r),
        .q_bit_o   (step_qbit)
    );

    assign q_shift = {q_q[WIDTH-2:0], step_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = dvs_zero ? DONE : RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath next-state; results land in quo/rem on the edge that enters DONE.
    always_comb begin
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dbz_d     = dvs_zero;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (dvs_zero) begin
                        quo_d = '0;
                        rem_d = dividend;
                    end else begin
                        r_d   = '0;
                        q_d   = a_mag;
                        dvs_d = b_mag;
                        cnt_d = CNT_W'(WIDTH - 1);
                    end
                end
            end
            RUN: begin
                r_d = step_r;
                q_d = q_shift;
                if (cnt_q == '0) begin
                    quo_d = neg_if(q_shift, neg_quo_q);
                    rem_d = neg_if(step_r, neg_rem_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            q_q       <= q_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_udiv_32.sv
// Self-checking bench for udiv_32: arithmetic reference model plus directed vectors.
module tb_udiv_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
`ifdef DIV_SIGNED_EN
    logic        signed_op = 1'b0;
`endif
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    udiv_32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef DIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        logic [31:0] ma, mb;
        dz = (b == 0);
        if (b == 0) begin
            q = 0;
            r = a;
        end else if (s) begin
            ma = a[31] ? -a : a;
            mb = b[31] ? -b : b;
            q  = ma / mb;
            r  = ma % mb;
            if (a[31] ^ b[31]) q = -q;
            if (a[31]) r = -r;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Model: cycles remaining until back in IDLE; done is the last of them.
    int          left = 0;
    logic [31:0] pend_q = '0, pend_r = '0, exp_q = '0, exp_r = '0;
    logic        pend_dz = 1'b0, exp_dz = 1'b0;
    logic        cur_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left   = 0;
            exp_q  = 0;
            exp_r  = 0;
            exp_dz = 0;
        end else if (left > 0) begin
            left--;
            if (left == 1) begin
                exp_q  = pend_q;
                exp_r  = pend_r;
                exp_dz = pend_dz;
            end
        end else if (start) begin
`ifdef DIV_SIGNED_EN
            cur_s = signed_op;
`else
            cur_s = 1'b0;
`endif
            ref_div(dividend, divisor, cur_s, pend_q, pend_r, pend_dz);
            left = (divisor == 0) ? 1 : 33;
            if (left == 1) begin
                exp_q  = pend_q;
                exp_r  = pend_r;
                exp_dz = pend_dz;
            end
        end
    end

    always @(negedge clk) begin
        chk1("busy", busy, left > 0);
        chk1("done", done, left == 1);
        if (left <= 1) begin
            chk32("quotient", quotient, exp_q);
            chk32("remainder", remainder, exp_r);
            chk1("div_by_zero", div_by_zero, exp_dz);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
`ifdef DIV_SIGNED_EN
        signed_op = s;
`else
        if (s) $display("note: signed request issued in unsigned build");
`endif
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle cyc0 after acceptance; waits for done, bounded.
    task automatic wait_done(input string nm, input int cyc0, input int lat,
                             input logic [31:0] eq, input logic [31:0] er, input logic edz,
                             input logic lit);
        int cyc = cyc0;
        while (!done && cyc <= 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done after %0d cycles, want done at %0d", nm, cyc, lat);
        end else if (lit) begin
            n_cmp++;
            if (cyc != lat) begin
                n_bad++;
                $display("FAIL %s_latency: got %0d want %0d", nm, cyc, lat);
            end
            chk32({nm, "_q"}, quotient, eq);
            chk32({nm, "_r"}, remainder, er);
            chk1({nm, "_dz"}, div_by_zero, edz);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk32("rst_q", quotient, 32'h0);
        chk32("rst_r", remainder, 32'h0);
        chk1("rst_dz", div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(100, 7, 0);
        wait_done("t1", 1, 33, 14, 2, 0, 1);
        issue(32'hFFFFFFFF, 1, 0);
        wait_done("t2a", 1, 33, 32'hFFFFFFFF, 0, 0, 1);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        wait_done("t2b", 1, 33, 1, 0, 0, 1);
        issue(5, 0, 0);
        wait_done("t3a", 1, 1, 0, 5, 1, 1);
        issue(3, 10, 0);
        wait_done("t3b", 1, 33, 0, 3, 0, 1);
        issue(32'hFFFFFFFF, 32'h80000000, 0);
        wait_done("ext", 1, 33, 1, 32'h7FFFFFFF, 0, 1);
        issue(32'h12345678, 32'h100, 0);
        wait_done("shift", 1, 33, 32'h123456, 32'h78, 0, 1);
        issue(0, 5, 0);
        wait_done("zero", 1, 33, 0, 0, 0, 1);
        issue(7, 7, 0);
        wait_done("equal", 1, 33, 1, 0, 0, 1);

        // start while busy, and start during the done cycle, are ignored
        issue(100, 7, 0);
        repeat (9) @(negedge clk);
        dividend = 9;
        divisor  = 3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4a", 11, 33, 14, 2, 0, 1);
        start = 1'b1;
        @(negedge clk);
        chk1("t4_done_start_ignored", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("t4b", 1, 33, 3, 0, 0, 1);

        // asynchronous reset mid-operation
        issue(100, 7, 0);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_done", done, 1'b0);
        chk32("t5_q", quotient, 32'h0);
        chk32("t5_r", remainder, 32'h0);
        chk1("t5_dz", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(50, 6, 0);
        wait_done("t5b", 1, 33, 8, 2, 0, 1);

`ifdef DIV_SIGNED_EN
        issue(32'hFFFFFFF9, 2, 1);
        wait_done("s_neg7_2", 1, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 1);
        issue(7, 32'hFFFFFFFE, 1);
        wait_done("s_7_neg2", 1, 33, 32'hFFFFFFFD, 1, 0, 1);
        issue(32'h80000000, 32'hFFFFFFFF, 1);
        wait_done("s_ovf", 1, 33, 32'h80000000, 0, 0, 1);
        issue(32'hFFFFFFF9, 0, 1);
        wait_done("s_dz", 1, 1, 0, 32'hFFFFFFF9, 1, 1);
        issue(32'hFFFFFFF9, 2, 0);
        wait_done("u_big", 1, 33, 32'h7FFFFFFC, 1, 0, 1);
        for (int k = 0; k < 1000; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            issue(a, b, 1'($urandom_range(0, 1)));
            wait_done("sweep", 1, 0, 0, 0, 0, 0);
        end
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
